// File: rtl/conv_pkg.sv
// Shared convolution package: mode codes used by the top FSM and the loop
// sequencer, default layer dimensions, and the sequencer state enum.
package conv_pkg;

  typedef enum logic [1:0] {
    MODE_IDLE  = 2'd0,
    MODE_CONV1 = 2'd1,
    MODE_CONV2 = 2'd2,
    MODE_DONE  = 2'd3
  } mode_e;

  localparam int C1_OCH_DEF = 6;
  localparam int C1_OW_DEF  = 24;
  localparam int C2_ICH_DEF = 6;
  localparam int C2_OCH_DEF = 16;
  localparam int C2_OW_DEF  = 8;
  localparam int DRAIN_DEF  = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN1,
    S_DRAIN1,
    S_WAIT1,
    S_RUN2,
    S_DRAIN2,
    S_WAIT2
  } state_e;

endpackage

// File: rtl/loop_cnt.sv
// Wrap counter for one loop level: counts 0..last on enable, pulses wrap
// combinationally on the enabled cycle that returns it to 0.
module loop_cnt #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         srstn,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] last,
  output logic [W-1:0] value,
  output logic         wrap
);

  assign wrap = en && (value == last);

  always_ff @(posedge clk) begin
    if (!srstn || clr) begin
      value <= '0;
    end else if (en) begin
      value <= wrap ? '0 : value + W'(1);
    end
  end

endmodule

// File: rtl/conv_loop_ctrl.sv
// Loop sequencer for CONV1/CONV2: issues per-beat och/ich/row/col indices,
// waits DRAIN cycles after the last beat, then pulses the layer done flag.
// Optional stall counter port is built when CONV_LOOP_PERF_EN is defined.
//
// state  | meaning
// IDLE   | no layer active, counters held at 0
// RUN1   | issuing CONV1 beats
// DRAIN1 | last CONV1 beat accepted, waiting for datapath to empty
// WAIT1  | conv1_done sent, waiting for mode to move off CONV1
// RUN2   | issuing CONV2 beats
// DRAIN2 | last CONV2 beat accepted, waiting for datapath to empty
// WAIT2  | conv_done sent, waiting for mode to move off CONV2
module conv_loop_ctrl
  import conv_pkg::*;
#(
  parameter int C1_OCH = C1_OCH_DEF,
  parameter int C1_OW  = C1_OW_DEF,
  parameter int C2_ICH = C2_ICH_DEF,
  parameter int C2_OCH = C2_OCH_DEF,
  parameter int C2_OW  = C2_OW_DEF,
  parameter int DRAIN  = DRAIN_DEF
) (
  input  logic       clk,
  input  logic       srstn,
  input  logic [1:0] mode,
  input  logic       issue_ready,
  output logic       issue_valid,
  output logic [4:0] och,
  output logic [2:0] ich,
  output logic [4:0] row,
  output logic [4:0] col,
  output logic       acc_clr,
  output logic       acc_wr,
  output logic       conv1_done,
  output logic       conv_done
`ifdef CONV_LOOP_PERF_EN
  , output logic [31:0] perf_stall_cnt
`endif
);

  localparam int DW = (DRAIN > 1) ? $clog2(DRAIN) : 1;

  state_e          state, state_nx;
  logic            running, running_nx, l2, beat, clr;
  logic            done1_nx, done2_nx;
  logic [DW-1:0]   drain_cnt;
  logic [4:0]      och_last, row_last, col_last;
  logic [2:0]      ich_last;
  logic            col_wrap, row_wrap, ich_wrap, och_wrap;
  logic            ich_en, och_en;

  assign running    = (state == S_RUN1) || (state == S_RUN2);
  assign running_nx = (state_nx == S_RUN1) || (state_nx == S_RUN2);
  assign l2         = (state == S_RUN2);
  assign beat       = issue_valid && issue_ready;
  assign clr        = !running;

  assign col_last = l2 ? 5'(C2_OW - 1)  : 5'(C1_OW - 1);
  assign row_last = l2 ? 5'(C2_OW - 1)  : 5'(C1_OW - 1);
  assign och_last = l2 ? 5'(C2_OCH - 1) : 5'(C1_OCH - 1);
  assign ich_last = 3'(C2_ICH - 1);

  // CONV1 skips the ich level: row carries straight into och
  assign ich_en = l2 && row_wrap;
  assign och_en = l2 ? ich_wrap : row_wrap;

  loop_cnt #(.W(5)) u_col (.clk(clk), .srstn(srstn), .en(beat),     .clr(clr),
                           .last(col_last), .value(col), .wrap(col_wrap));
  loop_cnt #(.W(5)) u_row (.clk(clk), .srstn(srstn), .en(col_wrap), .clr(clr),
                           .last(row_last), .value(row), .wrap(row_wrap));
  loop_cnt #(.W(3)) u_ich (.clk(clk), .srstn(srstn), .en(ich_en),   .clr(clr),
                           .last(ich_last), .value(ich), .wrap(ich_wrap));
  loop_cnt #(.W(5)) u_och (.clk(clk), .srstn(srstn), .en(och_en),   .clr(clr),
                           .last(och_last), .value(och), .wrap(och_wrap));

  assign acc_clr = issue_valid && (!l2 || (ich == 3'd0));
  assign acc_wr  = issue_valid && (!l2 || (ich == ich_last));

  always_comb begin
    state_nx = state;
    done1_nx = 1'b0;
    done2_nx = 1'b0;
    case (state)
      S_IDLE: begin
        if (mode == MODE_CONV1)      state_nx = S_RUN1;
        else if (mode == MODE_CONV2) state_nx = S_RUN2;
      end
      S_RUN1: begin
        if (mode != MODE_CONV1)  state_nx = S_IDLE;
        else if (och_wrap)       state_nx = S_DRAIN1;
      end
      S_DRAIN1: begin
        if (mode != MODE_CONV1) begin
          state_nx = S_IDLE;
        end else if (drain_cnt == '0) begin
          state_nx = S_WAIT1;
          done1_nx = 1'b1;
        end
      end
      S_WAIT1: begin
        if (mode == MODE_CONV2)      state_nx = S_RUN2;
        else if (mode != MODE_CONV1) state_nx = S_IDLE;
      end
      S_RUN2: begin
        if (mode != MODE_CONV2)  state_nx = S_IDLE;
        else if (och_wrap)       state_nx = S_DRAIN2;
      end
      S_DRAIN2: begin
        if (mode != MODE_CONV2) begin
          state_nx = S_IDLE;
        end else if (drain_cnt == '0) begin
          state_nx = S_WAIT2;
          done2_nx = 1'b1;
        end
      end
      S_WAIT2: begin
        if (mode != MODE_CONV2) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!srstn) begin
      state       <= S_IDLE;
      issue_valid <= 1'b0;
      conv1_done  <= 1'b0;
      conv_done   <= 1'b0;
      drain_cnt   <= '0;
    end else begin
      state       <= state_nx;
      issue_valid <= running_nx;
      conv1_done  <= done1_nx;
      conv_done   <= done2_nx;
      // reloaded every RUN cycle so DRAINx always starts from DRAIN-1
      if (running)                drain_cnt <= DW'(DRAIN - 1);
      else if (drain_cnt != '0)   drain_cnt <= drain_cnt - DW'(1);
    end
  end

`ifdef CONV_LOOP_PERF_EN
  always_ff @(posedge clk) begin
    if (!srstn) begin
      perf_stall_cnt <= '0;
    end else if (state == S_IDLE && running_nx) begin
      perf_stall_cnt <= '0;
    end else if (issue_valid && !issue_ready && perf_stall_cnt != '1) begin
      perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_conv_loop_ctrl.sv
// Self-checking bench for conv_loop_ctrl: beat-index model from loop arithmetic,
// directed layer runs, random stalls, abort and back-to-back layer change.
module tb_conv_loop_ctrl;

  localparam int C1_OCH = 6, C1_OW = 24, C2_ICH = 6, C2_OCH = 16, C2_OW = 8, DRAIN = 4;
  localparam int TOT1 = C1_OCH * C1_OW * C1_OW;
  localparam int TOT2 = C2_OCH * C2_ICH * C2_OW * C2_OW;

  logic        clk = 1'b0;
  logic        srstn, issue_ready, issue_valid;
  logic [1:0]  mode;
  logic [4:0]  och, row, col;
  logic [2:0]  ich;
  logic        acc_clr, acc_wr, conv1_done, conv_done;
`ifdef CONV_LOOP_PERF_EN
  logic [31:0] perf_stall_cnt;
`endif

  int vecs = 0, errs = 0;
  int cyc = 0, k = 0, layer = 0, active = 0;
  int d1 = 0, d2 = 0, stalls = 0, last_cyc = 0;
  logic [19:0] last_vec = '0;

  always #5 clk = ~clk;

  conv_loop_ctrl dut (
    .clk(clk), .srstn(srstn), .mode(mode), .issue_ready(issue_ready),
    .issue_valid(issue_valid), .och(och), .ich(ich), .row(row), .col(col),
    .acc_clr(acc_clr), .acc_wr(acc_wr), .conv1_done(conv1_done), .conv_done(conv_done)
`ifdef CONV_LOOP_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [19:0] exp_beat(input int lay, input int n);
    int o, i, r, c;
    logic clr_e, wr_e;
    if (lay == 1) begin
      o = n / (C1_OW * C1_OW);
      i = 0;
      r = (n / C1_OW) % C1_OW;
      c = n % C1_OW;
      clr_e = 1'b1;
      wr_e  = 1'b1;
    end else begin
      o = n / (C2_ICH * C2_OW * C2_OW);
      i = (n / (C2_OW * C2_OW)) % C2_ICH;
      r = (n / C2_OW) % C2_OW;
      c = n % C2_OW;
      clr_e = (i == 0);
      wr_e  = (i == C2_ICH - 1);
    end
    return {o[4:0], i[2:0], r[4:0], c[4:0], clr_e, wr_e};
  endfunction

  function automatic int total(input int lay);
    return (lay == 1) ? TOT1 : TOT2;
  endfunction

  wire [19:0] dut_vec = {och, ich, row, col, acc_clr, acc_wr};

  // Compare process: every cycle with valid high must carry the model's next beat
  always @(negedge clk) begin
    cyc++;
    if (srstn) begin
      if (issue_valid) begin
        if (active == 0 || k >= total(layer)) begin
          check("spurious_valid", {31'd0, issue_valid}, 32'd0);
        end else begin
          check("beat_idx", {12'd0, dut_vec}, {12'd0, exp_beat(layer, k)});
          if (issue_ready) begin
            if (k == total(layer) - 1) begin
              last_vec = dut_vec;
              last_cyc = cyc;
            end
            k++;
          end else begin
            stalls++;
          end
        end
      end
      if (conv1_done) begin
        d1++;
        check("conv1_done_lat", cyc - last_cyc, DRAIN + 1);
        check("conv1_done_beats", k, TOT1);
      end
      if (conv_done) begin
        d2++;
        check("conv_done_lat", cyc - last_cyc, DRAIN + 1);
        check("conv_done_beats", k, TOT2);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_layer(input int l);
    layer  = l;
    k      = 0;
    active = 1;
    stalls = 0;
    mode   = 2'(l);
  endtask

  task automatic wait_done(input int l, input int target, input int budget, input bit rnd);
    int n;
    n = 0;
    while (((l == 1) ? d1 : d2) < target && n < budget) begin
      if (rnd) issue_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    if (n >= budget) check("done_timeout", ((l == 1) ? d1 : d2), target);
  endtask

  initial begin
    int n;
    srstn = 1'b0;
    mode = 2'd1;
    issue_ready = 1'b1;
    repeat (3) tick();
    check("rst_outputs", {16'd0, issue_valid, dut_vec, conv1_done, conv_done, 1'b0},
          32'd0);

    // release with CONV1 already requested
    start_layer(1);
    srstn = 1'b1;
    check("rel_valid_lo", {31'd0, issue_valid}, 32'd0);
    tick();
    check("rel_valid_hi", {31'd0, issue_valid}, 32'd1);
    check("rel_first_idx", {12'd0, dut_vec}, {12'd0, 5'd0, 3'd0, 5'd0, 5'd0, 2'b11});
    wait_done(1, 1, TOT1 + 50, 1'b0);
    check("c1_done_cnt", d1, 1);
    check("c1_last_beat", {12'd0, last_vec}, {12'd0, 5'd5, 3'd0, 5'd23, 5'd23, 2'b11});
    mode = 2'd0;
    tick();
    active = 0;
    repeat (3) tick();
    check("c1_done_once", d1, 1);

    start_layer(2);
    wait_done(2, 1, TOT2 + 50, 1'b0);
    check("c2_done_cnt", d2, 1);
    check("c2_last_beat", {12'd0, last_vec}, {12'd0, 5'd15, 3'd5, 5'd7, 5'd7, 2'b01});
    mode = 2'd0;
    tick();
    active = 0;
    tick();

    mode = 2'd3;
    repeat (5) tick();
    check("mode3_ignored", {31'd0, issue_valid}, 32'd0);
    mode = 2'd0;
    tick();

    // random backpressure
    start_layer(1);
    wait_done(1, 2, 4 * TOT1, 1'b1);
    issue_ready = 1'b1;
    check("rnd_done_cnt", d1, 2);
`ifdef CONV_LOOP_PERF_EN
    check("perf_stalls", perf_stall_cnt, stalls);
`endif
    mode = 2'd0;
    tick();
    active = 0;
    tick();

    // abort at beat 1000
    start_layer(1);
    n = 0;
    while (k < 1000 && n < 2000) begin
      tick();
      n++;
    end
    check("abort_reached", (k >= 1000) ? 1 : 0, 1);
    mode = 2'd0;
    tick();
    active = 0;
    check("abort_idle", {31'd0, issue_valid}, 32'd0);
    repeat (20) tick();
    check("abort_no_done", d1, 2);

    // restart, then hand straight over to CONV2
    start_layer(1);
    tick();
    check("restart_idx", {12'd0, issue_valid, dut_vec[19:2]}, {12'd0, 1'b1, 18'd0});
    wait_done(1, 3, TOT1 + 50, 1'b0);
    check("b2b_gap_valid", {31'd0, issue_valid}, 32'd0);
    layer = 2;
    k = 0;
    active = 1;
    mode = 2'd2;
    tick();
    check("b2b_c2_start", {12'd0, issue_valid, dut_vec[19:2]}, {12'd0, 1'b1, 18'd0});
    wait_done(2, 2, TOT2 + 50, 1'b0);
    check("b2b_done_cnts", {d1[15:0], d2[15:0]}, {16'd3, 16'd2});
    mode = 2'd0;
    tick();
    active = 0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
